mux_sel_scheduler: RTL

//  Upstream feeder for the 4:1 W-bit word mux: four 1-entry input buffers drive D0..D3,
//  and a round-robin scheduler drives Sel.

---
 rtl/mux_sel_scheduler_pkg.sv | 13 +
 rtl/mux_sel_scheduler_if.sv | 32 +++
 rtl/mux_sel_scheduler_rr_arbiter4.sv | 30 +++
 rtl/mux_sel_scheduler.sv | 127 ++++++++++++
 4 files changed

// File: rtl/mux_sel_scheduler_pkg.sv
// Shared definitions for the mux select scheduler slice.
//   NCH           number of input channels feeding the 4:1 word mux
//   SEL_W         width of the mux select
//   sched_state_t scheduler FSM state
//   ch_mask_t     one bit per channel
package mux_sched_pkg;
  localparam int NCH   = 4;
  localparam int SEL_W = 2;

  typedef enum logic {IDLE, PRESENT} sched_state_t;

  typedef logic [NCH-1:0] ch_mask_t;
endpackage

// File: rtl/mux_sel_scheduler_if.sv
// Bus between the scheduler and its surroundings.
//   in_valid/in_ready/in_data : per-channel write handshake into the 1-entry buffers
//   D0..D3                    : buffer contents, wired to the mux data inputs
//   Sel                       : registered mux select
//   out_valid/out_ready       : consumer handshake for the word D[Sel]
// Modport master is the scheduler side, slave is the producer/consumer side.
interface mux_sel_scheduler_if #(
  parameter int W = 4
);
  import mux_sched_pkg::*;

  logic [NCH-1:0]          in_valid;
  logic [NCH-1:0]          in_ready;
  logic [NCH-1:0][W-1:0]   in_data;
  logic [W-1:0]            D0;
  logic [W-1:0]            D1;
  logic [W-1:0]            D2;
  logic [W-1:0]            D3;
  logic [SEL_W-1:0]        Sel;
  logic                    out_valid;
  logic                    out_ready;

  modport master (
    input  in_valid, in_data, out_ready,
    output in_ready, D0, D1, D2, D3, Sel, out_valid
  );

  modport slave (
    output in_valid, in_data, out_ready,
    input  in_ready, D0, D1, D2, D3, Sel, out_valid
  );
endinterface

// File: rtl/mux_sel_scheduler_rr_arbiter4.sv
// Combinational 4-way round-robin picker.
//   mask : channels eligible for a grant
//   last : most recently granted channel (lowest priority this round)
//   any  : at least one mask bit set
//   pick : first set mask bit scanning last+1, last+2, ... modulo 4
module rr_arbiter4
  import mux_sched_pkg::*;
(
  input  ch_mask_t         mask,
  input  logic [SEL_W-1:0] last,
  output logic             any,
  output logic [SEL_W-1:0] pick
);

  always_comb begin
    logic [SEL_W-1:0] idx;
    any  = 1'b0;
    pick = '0;
    idx  = '0;
    // Scan from farthest to nearest so the nearest candidate after 'last' wins.
    for (int k = NCH; k >= 1; k--) begin
      idx = last + SEL_W'(k);
      if (mask[idx]) begin
        any  = 1'b1;
        pick = idx;
      end
    end
  end

endmodule

// File: rtl/mux_sel_scheduler.sv
// Upstream feeder for a 4:1 W-bit word mux. Four 1-entry buffers drive D0..D3
// and a round-robin scheduler drives Sel; one full channel at a time is offered
// to the consumer through out_valid/out_ready.
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   bus        mux_sel_scheduler_if.master (write handshake, D0..D3, Sel, out handshake)
//   grant_cnt  per-channel accepted-transfer counters, wrap modulo 2^CNT_W
//              (present only when SCHED_STATS_EN is defined)
// Optional feature macro: SCHED_STATS_EN
module mux_sel_scheduler
  import mux_sched_pkg::*;
#(
  parameter int W     = 4
`ifdef SCHED_STATS_EN
  ,
  parameter int CNT_W = 8
`endif
) (
  input  logic                          clk,
  input  logic                          rst_n,
  mux_sel_scheduler_if.master           bus
`ifdef SCHED_STATS_EN
  ,
  output logic [NCH-1:0][CNT_W-1:0]     grant_cnt
`endif
);

  sched_state_t     state_q, state_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [SEL_W-1:0] last_q, last_d;
  ch_mask_t         full_q, full_d;
  logic [W-1:0]     data_q [NCH];

  ch_mask_t         wr;
  ch_mask_t         clr;
  ch_mask_t         sel_onehot;
  logic             accept;

  ch_mask_t         arb_mask;
  logic [SEL_W-1:0] arb_last;
  logic             arb_any;
  logic [SEL_W-1:0] arb_pick;

  rr_arbiter4 u_arb (
    .mask (arb_mask),
    .last (arb_last),
    .any  (arb_any),
    .pick (arb_pick)
  );

  // A slot only accepts when empty, so a presented word can never be overwritten.
  assign wr         = bus.in_valid & ~full_q;
  assign sel_onehot = ch_mask_t'(1) << sel_q;

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    last_d   = last_q;
    accept   = 1'b0;
    clr      = '0;
    arb_mask = full_q;
    arb_last = last_q;
    unique case (state_q)
      IDLE: begin
        if (arb_any) begin
          sel_d   = arb_pick;
          state_d = PRESENT;
        end
      end
      PRESENT: begin
        // Next pick assumes the current slot is consumed; uses the registered
        // full mask, so a write landing this cycle is only seen next cycle.
        arb_mask = full_q & ~sel_onehot;
        arb_last = sel_q;
        if (bus.out_ready) begin
          accept = 1'b1;
          clr    = sel_onehot;
          last_d = sel_q;
          if (arb_any) begin
            sel_d = arb_pick;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    full_d = (full_q | wr) & ~clr;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sel_q   <= '0;
      last_q  <= SEL_W'(NCH - 1);
      full_q  <= '0;
      for (int i = 0; i < NCH; i++) data_q[i] <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
      full_q  <= full_d;
      for (int i = 0; i < NCH; i++) begin
        if (wr[i]) data_q[i] <= bus.in_data[i];
      end
    end
  end

`ifdef SCHED_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      grant_cnt <= '0;
    end else if (accept) begin
      grant_cnt[sel_q] <= grant_cnt[sel_q] + CNT_W'(1);
    end
  end
`endif

  assign bus.in_ready  = ~full_q;
  assign bus.D0        = data_q[0];
  assign bus.D1        = data_q[1];
  assign bus.D2        = data_q[2];
  assign bus.D3        = data_q[3];
  assign bus.Sel       = sel_q;
  assign bus.out_valid = (state_q == PRESENT);

endmodule
